hintdec_unpack: RTL and testbench

- Inverse of the makehint encoder: decodes the ML-DSA packed hint field of a signature (OMEGA index bytes followed by K cumulative count bytes).
- Expands the field into K polynomials of 256 hint bits and writes them 4 coefficients per cycle into the usehint memory.
- Performs the FIPS 204 HintBitUnpack malformed-encoding checks and flags a failure.
- Sits between the signature register array and the usehint datapath in the verify flow.

---
 rtl/hintdec_unpack.sv | 212 +++++++++++++++++++++
 tb/tb_hintdec_unpack.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hintdec_unpack.sv
// Decodes the packed ML-DSA hint field into K polynomials of 256 hint bits, 4 bits per write.
// Optional build macro MLDSA_HINTDEC_EARLY_ABORT_EN ends the decode at the first malformed byte.
module hintdec_unpack #(
  parameter int unsigned OMEGA      = 75,
  parameter int unsigned K          = 8,
  parameter int unsigned SIG_ADDR_W = 5,
  parameter int unsigned MEM_ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  zeroize,
  input  logic                  hintdec_en,
  input  logic [MEM_ADDR_W-1:0] dest_base_addr,
  output logic                  hint_rd_en,
  output logic [SIG_ADDR_W-1:0] hint_rd_addr,
  input  logic [31:0]           hint_rd_data,
  output logic                  mem_wr_en,
  output logic [MEM_ADDR_W-1:0] mem_wr_addr,
  output logic [3:0]            mem_wr_data,
  output logic                  busy,
  output logic                  hintdec_done,
  output logic                  hintdec_err
);

`ifdef MLDSA_HINTDEC_EARLY_ABORT_EN
  localparam bit EarlyAbort = 1'b1;
`else
  localparam bit EarlyAbort = 1'b0;
`endif

  localparam int unsigned IW       = (K > 1) ? $clog2(K) : 1;
  localparam logic [7:0]  OmegaB   = 8'(OMEGA);
  localparam logic [7:0]  CntLast  = 8'(OMEGA + K - 1);
  localparam logic [7:0]  PadLast  = 8'(OMEGA - 1);
  localparam logic [IW-1:0] PolyLast = IW'(K - 1);

  typedef enum logic [2:0] {
    HD_IDLE, HD_RD_CNT, HD_LOAD_IDX, HD_FLUSH, HD_CHK_PAD, HD_RD_MEM, HD_WAIT, HD_DONE
  } hd_state_e;

  hd_state_e             state_q, state_d, ret_q, ret_d;
  logic [7:0]            ptr_q;       // byte offset into the hint field
  logic [7:0]            prev_q;
  logic [7:0]            last_y_q;
  logic [7:0]            cnt_q [K];
  logic [IW-1:0]         i_q;
  logic [5:0]            j_q;
  logic [255:0]          bitmap_q;
  logic [31:0]           buf_q;
  logic [SIG_ADDR_W-1:0] buf_addr_q;
  logic                  buf_vld_q;
  logic [MEM_ADDR_W-1:0] base_q;
  logic                  err_q, cnt_bad_q;

  logic                  consume, err_set, cnt_bad_set;
  logic [SIG_ADDR_W-1:0] rd_word;
  logic                  byte_hit;
  logic [7:0]            cur_byte, cnt_cur;
  logic                  cnt_chk_fail, idx_order_fail;
  logic [IW-1:0]         cnt_sel;

  assign rd_word        = SIG_ADDR_W'(ptr_q >> 2);
  assign byte_hit       = buf_vld_q && (buf_addr_q == rd_word);
  assign cur_byte       = buf_q[{ptr_q[1:0], 3'b000} +: 8];
  assign cnt_cur        = cnt_q[i_q];
  assign cnt_chk_fail   = (cnt_cur < prev_q) || (cnt_cur > OmegaB);
  assign idx_order_fail = (ptr_q > prev_q) && (cur_byte <= last_y_q);
  assign cnt_sel        = IW'(ptr_q - OmegaB);

  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    consume     = 1'b0;
    err_set     = 1'b0;
    cnt_bad_set = 1'b0;
    case (state_q)
      HD_IDLE: if (hintdec_en) state_d = HD_RD_CNT;
      HD_RD_CNT: begin
        if (!byte_hit) begin
          state_d = HD_RD_MEM;
          ret_d   = HD_RD_CNT;
        end else begin
          consume = 1'b1;
          if (ptr_q == CntLast) state_d = HD_LOAD_IDX;
        end
      end
      HD_LOAD_IDX: begin
        if (cnt_bad_q) begin
          state_d = HD_FLUSH;
        end else if (cnt_chk_fail) begin
          err_set     = 1'b1;
          cnt_bad_set = 1'b1;
          state_d     = EarlyAbort ? HD_DONE : HD_FLUSH;
        end else if (ptr_q == cnt_cur) begin
          state_d = HD_FLUSH;
        end else if (!byte_hit) begin
          state_d = HD_RD_MEM;
          ret_d   = HD_LOAD_IDX;
        end else begin
          consume = 1'b1;
          if (idx_order_fail) begin
            err_set = 1'b1;
            if (EarlyAbort) state_d = HD_DONE;
          end
        end
      end
      HD_FLUSH: begin
        if (j_q == 6'd63) begin
          if (i_q != PolyLast)                   state_d = HD_LOAD_IDX;
          else if (cnt_bad_q || cnt_cur == OmegaB) state_d = HD_DONE;
          else                                   state_d = HD_CHK_PAD;
        end
      end
      HD_CHK_PAD: begin
        if (!byte_hit) begin
          state_d = HD_RD_MEM;
          ret_d   = HD_CHK_PAD;
        end else begin
          consume = 1'b1;
          if (cur_byte != 8'd0) begin
            err_set = 1'b1;
            if (EarlyAbort) state_d = HD_DONE;
          end
          if (ptr_q == PadLast) state_d = HD_DONE;
        end
      end
      HD_RD_MEM: state_d = HD_WAIT;
      HD_WAIT:   state_d = ret_q;
      HD_DONE:   state_d = HD_IDLE;
      default:   state_d = HD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || zeroize) begin
      state_q    <= HD_IDLE;
      ret_q      <= HD_IDLE;
      ptr_q      <= '0;
      prev_q     <= '0;
      last_y_q   <= '0;
      for (int n = 0; n < int'(K); n++) cnt_q[n] <= '0;
      i_q        <= '0;
      j_q        <= '0;
      bitmap_q   <= '0;
      buf_q      <= '0;
      buf_addr_q <= '0;
      buf_vld_q  <= 1'b0;
      base_q     <= '0;
      err_q      <= 1'b0;
      cnt_bad_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      if (err_set)     err_q     <= 1'b1;
      if (cnt_bad_set) cnt_bad_q <= 1'b1;
      case (state_q)
        HD_IDLE: begin
          if (hintdec_en) begin
            base_q    <= dest_base_addr;
            ptr_q     <= OmegaB;
            prev_q    <= '0;
            i_q       <= '0;
            j_q       <= '0;
            bitmap_q  <= '0;
            buf_vld_q <= 1'b0;
            err_q     <= 1'b0;
            cnt_bad_q <= 1'b0;
          end
        end
        HD_RD_CNT: begin
          if (consume) begin
            cnt_q[cnt_sel] <= cur_byte;
            ptr_q          <= (ptr_q == CntLast) ? 8'd0 : ptr_q + 8'd1;
          end
        end
        HD_LOAD_IDX: begin
          if (consume) begin
            bitmap_q[cur_byte] <= 1'b1;
            last_y_q           <= cur_byte;
            ptr_q              <= ptr_q + 8'd1;
          end
        end
        HD_FLUSH: begin
          j_q <= j_q + 6'd1;
          if (j_q == 6'd63) begin
            bitmap_q <= '0;
            prev_q   <= cnt_cur;
            if (i_q != PolyLast) i_q <= i_q + 1'b1;
          end
        end
        HD_CHK_PAD: if (consume) ptr_q <= ptr_q + 8'd1;
        HD_WAIT: begin
          buf_q      <= hint_rd_data;
          buf_addr_q <= rd_word;
          buf_vld_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy         = (state_q != HD_IDLE);
  assign hintdec_done = (state_q == HD_DONE);
  assign hintdec_err  = err_q && ((state_q == HD_DONE) || (state_q == HD_IDLE));
  assign hint_rd_en   = (state_q == HD_RD_MEM);
  assign hint_rd_addr = hint_rd_en ? rd_word : '0;
  assign mem_wr_en    = (state_q == HD_FLUSH);
  assign mem_wr_addr  = mem_wr_en ? base_q + MEM_ADDR_W'({i_q, j_q}) : '0;
  // A set error blanks every later write so no partial hint set leaks out.
  assign mem_wr_data  = (mem_wr_en && !err_q) ? bitmap_q[{j_q, 2'b00} +: 4] : 4'd0;

endmodule

// File: tb/tb_hintdec_unpack.sv
// Bench for hintdec_unpack: directed and random hint fields checked against a HintBitUnpack model.
module tb_hintdec_unpack;
  localparam int OMEGA = 75, K = 8, SIG_ADDR_W = 5, MEM_ADDR_W = 10, NB = OMEGA + K;
  localparam int BOUND = 2 * (OMEGA + K) + K * 64 + 8;

  logic clk = 1'b0, rst = 1'b1, zeroize = 1'b0, hintdec_en = 1'b0;
  logic [MEM_ADDR_W-1:0] dest_base_addr = '0;
  logic hint_rd_en, mem_wr_en, busy, hintdec_done, hintdec_err;
  logic [SIG_ADDR_W-1:0] hint_rd_addr;
  logic [31:0] hint_rd_data = 32'hDEADBEEF;
  logic [MEM_ADDR_W-1:0] mem_wr_addr;
  logic [3:0] mem_wr_data;

  always #5 clk = ~clk;

  hintdec_unpack dut (
    .clk(clk), .rst(rst), .zeroize(zeroize), .hintdec_en(hintdec_en),
    .dest_base_addr(dest_base_addr), .hint_rd_en(hint_rd_en), .hint_rd_addr(hint_rd_addr),
    .hint_rd_data(hint_rd_data), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .busy(busy), .hintdec_done(hintdec_done),
    .hintdec_err(hintdec_err)
  );

  logic [7:0] field [NB];
  int tests = 0, fails = 0;
  logic [MEM_ADDR_W-1:0] wr_addr_q [$];
  logic [3:0] wr_data_q [$];
  logic rd_pend = 1'b0;
  logic [SIG_ADDR_W-1:0] rd_addr_s = '0;

  function automatic logic [31:0] word_of(input logic [SIG_ADDR_W-1:0] a);
    logic [31:0] w;
    w = '0;
    for (int b = 0; b < 4; b++)
      if (4 * int'(a) + b < NB) w[8*b +: 8] = field[4 * int'(a) + b];
    return w;
  endfunction

  always @(negedge clk) begin
    rd_pend = hint_rd_en;
    rd_addr_s = hint_rd_addr;
    if (mem_wr_en) begin
      wr_addr_q.push_back(mem_wr_addr);
      wr_data_q.push_back(mem_wr_data);
    end
  end

  // Read port model: data only valid in the cycle after the strobe, garbage otherwise.
  always @(posedge clk) begin
    #1;
    hint_rd_data = rd_pend ? word_of(rd_addr_s) : 32'hDEADBEEF;
  end

  logic [255:0] exp_h [K];
  logic exp_err;
  int exp_p;  // first poly whose flush sees the error (K if none before the pad check)

  task automatic model();
    int prev, c;
    bit cnt_bad;
    prev = 0; cnt_bad = 0; exp_err = 0; exp_p = K;
    for (int i = 0; i < K; i++) exp_h[i] = '0;
    for (int i = 0; i < K && !cnt_bad; i++) begin
      c = int'(field[OMEGA + i]);
      if (c < prev || c > OMEGA) begin
        exp_err = 1; cnt_bad = 1;
        if (exp_p == K) exp_p = i;
      end else begin
        for (int x = prev; x < c; x++) begin
          if (x > prev && field[x] <= field[x-1]) begin
            exp_err = 1;
            if (exp_p == K) exp_p = i;
          end
          exp_h[i][field[x]] = 1'b1;
        end
        prev = c;
      end
    end
    if (!cnt_bad)
      for (int x = prev; x < OMEGA; x++) if (field[x] != 8'd0) exp_err = 1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_field();
    for (int b = 0; b < NB; b++) field[b] = 8'd0;
  endtask

  task automatic rand_valid();
    int total, n, v, got;
    logic [255:0] m;
    clear_field();
    total = 0;
    for (int i = 0; i < K; i++) begin
      n = $urandom_range(0, 12);
      if (total + n > OMEGA) n = OMEGA - total;
      m = '0; got = 0;
      while (got < n) begin
        v = $urandom_range(0, 255);
        if (!m[v]) begin m[v] = 1'b1; got++; end
      end
      for (int y = 0; y < 256; y++) if (m[y]) begin field[total] = 8'(y); total++; end
      field[OMEGA + i] = 8'(total);
    end
  endtask

  task automatic start(input logic [MEM_ADDR_W-1:0] base);
    @(posedge clk); #1; dest_base_addr = base; hintdec_en = 1'b1;
    @(posedge clk); #1; hintdec_en = 1'b0; dest_base_addr = ~base;
  endtask

  task automatic run_case(input string name, input logic [MEM_ADDR_W-1:0] base,
                          input bit poke, output int wb);
    int cyc, exp_n, n_wr, bad_a, bad_d, lim, ci, cj;
    bit got;
    logic [MEM_ADDR_W-1:0] ea;
    logic [3:0] ed;
    model();
    wb = wr_addr_q.size();
    start(base);
    cyc = 0; got = 1'b0;
    while (!got && cyc <= BOUND) begin
      @(negedge clk); cyc++;
      if (cyc == 1) check({name, ":busy"}, busy, 1);
      hintdec_en = poke && (cyc == 5);
      if (hintdec_done) got = 1'b1;
    end
    hintdec_en = 1'b0;
    check({name, ":done"}, got, 1);
    check({name, ":latency"}, 32'(cyc <= BOUND), 1);
    check({name, ":err"}, hintdec_err, exp_err);
    @(negedge clk);
    check({name, ":done_pulse"}, hintdec_done, 0);
    check({name, ":err_held"}, hintdec_err, exp_err);
    check({name, ":idle"}, busy, 0);
`ifdef MLDSA_HINTDEC_EARLY_ABORT_EN
    exp_n = exp_p * 64;
`else
    exp_n = K * 64;
`endif
    n_wr = wr_addr_q.size() - wb;
    check({name, ":wr_count"}, n_wr, exp_n);
    lim = (n_wr < exp_n) ? n_wr : exp_n;
    bad_a = 0; bad_d = 0;
    for (int n = 0; n < lim; n++) begin
      ci = n / 64; cj = n % 64;
      ea = base + MEM_ADDR_W'(n);
      ed = (ci < exp_p) ? exp_h[ci][4*cj +: 4] : 4'd0;
      if (wr_addr_q[wb + n] !== ea) bad_a++;
      if (wr_data_q[wb + n] !== ed) bad_d++;
    end
    check({name, ":wr_addr_bad"}, bad_a, 0);
    check({name, ":wr_data_bad"}, bad_d, 0);
  endtask

  initial begin
    int wb, n0, cyc;
    clear_field();
    repeat (3) @(negedge clk);
    check("rst:rd_en", hint_rd_en, 0);
    check("rst:rd_addr", hint_rd_addr, 0);
    check("rst:wr_en", mem_wr_en, 0);
    check("rst:wr_addr", mem_wr_addr, 0);
    check("rst:wr_data", mem_wr_data, 0);
    check("rst:busy", busy, 0);
    check("rst:done", hintdec_done, 0);
    check("rst:err", hintdec_err, 0);
    rst = 1'b0;

    clear_field();
    run_case("zero", 10'h040, 0, wb);
    check("zero:no_err_const", exp_err, 0);

    clear_field();
    for (int i = 0; i < K; i++) field[OMEGA + i] = 8'd2;
    field[OMEGA + K - 1] = 8'd3;
    field[0] = 8'd0; field[1] = 8'd255; field[2] = 8'd5;
    run_case("basic", 10'h1f0, 0, wb);
    if (wr_data_q.size() >= wb + 512) begin
      check("basic:p0j0", wr_data_q[wb], 4'b0001);
      check("basic:p0j63", wr_data_q[wb + 63], 4'b1000);
      check("basic:p7j1", wr_data_q[wb + 7*64 + 1], 4'b0010);
    end

    clear_field();
    for (int i = 0; i < K; i++) field[OMEGA + i] = 8'd2;
    field[0] = 8'd7; field[1] = 8'd7;
    run_case("dup", 10'h000, 0, wb);

    clear_field();
    for (int i = 0; i < K; i++) field[OMEGA + i] = 8'd2;
    field[OMEGA] = 8'd3;
    field[0] = 8'd1; field[1] = 8'd2; field[2] = 8'd3;
    run_case("decr", 10'h100, 0, wb);

    clear_field();
    field[OMEGA + K - 1] = 8'd76;
    run_case("over", 10'h080, 0, wb);

    clear_field();
    field[OMEGA + K - 1] = 8'd2;
    field[0] = 8'd1; field[1] = 8'd9; field[OMEGA - 1] = 8'd1;
    run_case("pad", 10'h020, 0, wb);

    clear_field();
    field[OMEGA + K - 1] = 8'(OMEGA);
    for (int x = 0; x < OMEGA; x++) field[x] = 8'(3 * x);
    run_case("full", 10'h200, 0, wb);

    for (int r = 0; r < 6; r++) begin
      rand_valid();
      run_case($sformatf("rand%0d", r), 10'($urandom_range(0, 512)), r == 2, wb);
    end
    for (int r = 0; r < 4; r++) begin
      rand_valid();
      field[$urandom_range(0, NB - 1)] ^= 8'(1 << $urandom_range(0, 7));
      run_case($sformatf("mut%0d", r), 10'($urandom_range(0, 512)), 0, wb);
    end

    rand_valid();
    start(10'h010);
    repeat (40) @(negedge clk);
    zeroize = 1'b1;
    @(negedge clk);
    zeroize = 1'b0;
    check("zeroize:busy", busy, 0);
    check("zeroize:rd_en", hint_rd_en, 0);

    clear_field();
    field[OMEGA + K - 1] = 8'd1; field[0] = 8'd40;
    start(10'h000);
    cyc = 0;
    while (!(mem_wr_en && mem_wr_addr == 10'd30) && cyc < BOUND) begin
      @(negedge clk); cyc++;
    end
    check("rstmid:reach_j30", mem_wr_addr, 10'd30);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid:wr_en", mem_wr_en, 0);
    check("rstmid:rd_en", hint_rd_en, 0);
    check("rstmid:busy", busy, 0);
    check("rstmid:done", hintdec_done, 0);
    check("rstmid:err", hintdec_err, 0);
    check("rstmid:wr_addr", mem_wr_addr, 0);
    n0 = wr_addr_q.size();
    repeat (20) @(negedge clk);
    check("rstmid:no_writes", wr_addr_q.size(), n0);
    rand_valid();
    run_case("after_rst", 10'h0c0, 0, wb);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
